hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers.
REQ-002 SHALL have parameter RA_W, default 5, register address width (clog2 NUM_REGS).
REQ-003 SHALL have parameter CNT_W, default 3, width of per-register latency counter.
REQ-004 SHALL have parameter FWD_EN, default 1: 1 = per-instruction latency (bypass present); 0 = fixed latency NOFWD_LAT.
REQ-005 SHALL have parameter NOFWD_LAT, default 3, latency used for every writer when FWD_EN=0.
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports: dec_valid in 1 decode instruction valid; dec_rs1, dec_rs2 in RA_W source regs; dec_use_rs1, dec_use_rs2 in 1 source actually read.
REQ-008 SHALL have ports: dec_rd in RA_W dest reg; dec_rd_we in 1 writes rd; dec_lat in CNT_W cycles until result usable by a consumer.
REQ-009 SHALL have ports: flush in 1 kill decode instruction; ext_stall in 1 freeze whole pipeline; stat_clr in 1 clear stall counter.
REQ-010 SHALL have ports: pc_en out 1; if_id_en out 1; bubble_sel out 1 (NOP into ID/EX); busy out NUM_REGS pending-write vector; stall_cnt out 16 hazard-stall cycle count.

Function
REQ-011 SHALL keep one CNT_W counter cnt[r] per register r; cnt[0] SHALL be constant 0; busy[r] = (cnt[r] != 0).
REQ-012 hazard SHALL = dec_valid & ~flush & ((dec_use_rs1 & busy[dec_rs1]) | (dec_use_rs2 & busy[dec_rs2])), combinational from current counters.
REQ-013 pc_en and if_id_en SHALL = ~hazard & ~ext_stall.
REQ-014 bubble_sel SHALL = (hazard | (flush & dec_valid)) & ~ext_stall.
REQ-015 issue SHALL = dec_valid & ~hazard & ~flush & ~ext_stall; an issued instruction SHALL advance to EX that cycle.
REQ-016 eff_lat SHALL = dec_lat when FWD_EN=1, NOFWD_LAT when FWD_EN=0.
REQ-017 When ext_stall=1 all counters SHALL hold and no issue SHALL occur.
REQ-018 Otherwise each nonzero cnt[r] SHALL decrement by 1 per cycle.
REQ-019 On issue with dec_rd_we=1, dec_rd!=0, eff_lat!=0: cnt[dec_rd] SHALL load max(decremented cnt[dec_rd], eff_lat) (WAW keeps the later completion).
REQ-020 Issue with eff_lat=0, dec_rd=0 or dec_rd_we=0 SHALL leave that counter to normal decrement.
REQ-021 An instruction reading its own dec_rd SHALL see pre-update counter value (no self-stall).
REQ-022 Latency semantics: consumer in decode may issue in cycle t+eff_lat when producer issued in cycle t.
REQ-023 stall_cnt SHALL increment by 1 each cycle hazard=1 and ext_stall=0, saturating at 16'hFFFF.
REQ-024 stat_clr=1 SHALL zero stall_cnt that cycle, taking priority over increment.
REQ-025 flush SHALL never modify counters of already-issued instructions.

Reset
REQ-026 rst=1 SHALL asynchronously clear all cnt[r] and stall_cnt to 0; busy=0.
REQ-027 During and after reset with dec_valid=0, ext_stall=0: pc_en=1, if_id_en=1, bubble_sel=0.
REQ-028 Reset asserted mid-stall SHALL drop hazard the same cycle (counters zero) and discard pending writes.

Verification
REQ-029 Producer rd=5 lat=2 issues cycle 0; consumer rs1=5 in decode cycle 1 -> hazard=1, bubble_sel=1, pc_en=0 in cycle 1; issues cycle 2; stall_cnt=1.
REQ-030 FWD_EN=0, NOFWD_LAT=3: producer rd=7 (dec_lat=1) then consumer rs2=7 -> 2 stall cycles; busy[7] clears after cycle 2.
REQ-031 Writer rd=0 lat=3 then consumer rs1=0 -> no stall; busy=0 throughout.
REQ-032 cnt[9]=3 and ext_stall=1 for 4 cycles -> cnt[9] stays 3, pc_en=0, bubble_sel=0, stall_cnt unchanged; resumes decrementing after release.
REQ-033 Consumer with busy source and flush=1 -> pc_en=1, bubble_sel=1, no issue, stall_cnt unchanged; WAW: rd=4 lat=3 then rd=4 lat=1 -> busy[4] for 3 cycles from first issue.
REQ-034 Force 65536+ stall cycles -> stall_cnt=16'hFFFF saturates; stat_clr=1 -> 0 next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard with decode stall/bubble control.
// Each counter holds the cycles left before its result is usable.
module hazard_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int RA_W      = 5,
    parameter int CNT_W     = 3,
    parameter int FWD_EN    = 1,
    parameter int NOFWD_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [RA_W-1:0]     dec_rs1,
    input  logic [RA_W-1:0]     dec_rs2,
    input  logic                dec_use_rs1,
    input  logic                dec_use_rs2,
    input  logic [RA_W-1:0]     dec_rd,
    input  logic                dec_rd_we,
    input  logic [CNT_W-1:0]    dec_lat,
    input  logic                flush,
    input  logic                ext_stall,
    input  logic                stat_clr,
    output logic                pc_en,
    output logic                if_id_en,
    output logic                bubble_sel,
    output logic [NUM_REGS-1:0] busy,
    output logic [15:0]         stall_cnt
);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0][CNT_W-1:0] nxt;
    logic [CNT_W-1:0]               eff_lat;
    logic [CNT_W-1:0]               load_val;
    logic [CNT_W-1:0]               dec_v;
    logic                           hazard;
    logic                           issue;
    logic                           wr_hit;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    assign eff_lat = (FWD_EN != 0) ? dec_lat : CNT_W'(NOFWD_LAT);

    // The issue cycle itself counts as the first latency cycle.
    assign load_val = eff_lat - CNT_W'(1);

    assign hazard = dec_valid & ~flush &
                    ((dec_use_rs1 & busy[dec_rs1]) |
                     (dec_use_rs2 & busy[dec_rs2]));

    assign pc_en      = ~hazard & ~ext_stall;
    assign if_id_en   = ~hazard & ~ext_stall;
    assign bubble_sel = (hazard | (flush & dec_valid)) & ~ext_stall;

    assign issue  = dec_valid & ~hazard & ~flush & ~ext_stall;
    assign wr_hit = issue & dec_rd_we & (dec_rd != '0) &
                    (eff_lat != '0);

    always_comb begin
        nxt   = cnt;
        dec_v = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            dec_v  = (cnt[r] != '0) ? cnt[r] - CNT_W'(1) : '0;
            nxt[r] = dec_v;
            if (wr_hit && dec_rd == RA_W'(r) && load_val > dec_v) begin
                nxt[r] = load_val;
            end
        end
        nxt[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!ext_stall) begin
            cnt <= nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
        end else if (hazard && !ext_stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three configurations under one stimulus,
// checked against an absolute ready-time model plus directed literals.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, use1, use2, we, flush, ext_stall, stat_clr;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  lat;
    logic [2:0]  pc_en, if_id_en, bubble;
    logic [31:0] busy_v [3];
    logic [15:0] sc [3];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u_a (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(rs1), .dec_rs2(rs2),
        .dec_use_rs1(use1), .dec_use_rs2(use2),
        .dec_rd(rd), .dec_rd_we(we), .dec_lat(lat[2:0]),
        .flush(flush), .ext_stall(ext_stall), .stat_clr(stat_clr),
        .pc_en(pc_en[0]), .if_id_en(if_id_en[0]),
        .bubble_sel(bubble[0]), .busy(busy_v[0]), .stall_cnt(sc[0])
    );

    hazard_scoreboard #(.FWD_EN(0), .NOFWD_LAT(3)) u_b (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(rs1), .dec_rs2(rs2),
        .dec_use_rs1(use1), .dec_use_rs2(use2),
        .dec_rd(rd), .dec_rd_we(we), .dec_lat(lat[2:0]),
        .flush(flush), .ext_stall(ext_stall), .stat_clr(stat_clr),
        .pc_en(pc_en[1]), .if_id_en(if_id_en[1]),
        .bubble_sel(bubble[1]), .busy(busy_v[1]), .stall_cnt(sc[1])
    );

    hazard_scoreboard #(.CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(rs1), .dec_rs2(rs2),
        .dec_use_rs1(use1), .dec_use_rs2(use2),
        .dec_rd(rd), .dec_rd_we(we), .dec_lat(lat),
        .flush(flush), .ext_stall(ext_stall), .stat_clr(stat_clr),
        .pc_en(pc_en[2]), .if_id_en(if_id_en[2]),
        .bubble_sel(bubble[2]), .busy(busy_v[2]), .stall_cnt(sc[2])
    );

    // Model: ready[k][r] is the active-cycle index at which r is usable.
    int ready [3][32];
    int act [3];
    int st [3];

    function automatic int effl(int k);
        if (k == 1) return 3;
        if (k == 0) return int'(lat[2:0]);
        return int'(lat);
    endfunction

    function automatic bit mbusy(int k, int r);
        return (r != 0) && (ready[k][r] > act[k]);
    endfunction

    function automatic bit mhaz(int k);
        return dec_valid && !flush &&
               ((use1 && mbusy(k, int'(rs1))) ||
                (use2 && mbusy(k, int'(rs2))));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                act[k] = 0;
                st[k]  = 0;
                for (int r = 0; r < 32; r++) ready[k][r] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit h, iss;
                int e;
                h   = mhaz(k);
                iss = dec_valid && !h && !flush && !ext_stall;
                e   = effl(k);
                if (stat_clr) st[k] = 0;
                else if (h && !ext_stall && st[k] < 65535) st[k]++;
                if (!ext_stall) begin
                    if (iss && we && rd != 0 && e != 0 &&
                        act[k] + e > ready[k][rd])
                        ready[k][rd] = act[k] + e;
                    act[k]++;
                end
            end
        end
    end

    task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", n, got, exp);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [31:0] eb;
            logic [50:0] e, g;
            bit h;
            h = mhaz(k);
            for (int r = 0; r < 32; r++) eb[r] = mbusy(k, r);
            e = {!h && !ext_stall, !h && !ext_stall,
                 (h || (flush && dec_valid)) && !ext_stall,
                 eb, 16'(st[k])};
            g = {pc_en[k], if_id_en[k], bubble[k], busy_v[k], sc[k]};
            chk($sformatf("model_cmp_inst%0d", k), 64'(g), 64'(e));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; use1 = 0; use2 = 0; we = 0;
        rs1 = 0; rs2 = 0; rd = 0; lat = 0; flush = 0;
    endtask

    task automatic drain();
        idle();
        repeat (9) tick();
    endtask

    task automatic wr(int r, int l);
        idle();
        dec_valid = 1; we = 1; rd = 5'(r); lat = 8'(l);
    endtask

    task automatic cons1(int r);
        idle();
        dec_valid = 1; use1 = 1; rs1 = 5'(r);
    endtask

    task automatic cons2(int r);
        idle();
        dec_valid = 1; use2 = 1; rs2 = 5'(r);
    endtask

    initial begin
        idle();
        ext_stall = 0; stat_clr = 0; rst = 1;
        repeat (2) tick();
        #2;
        chk("rst_pc_en", 64'(pc_en), 64'h7);
        chk("rst_if_id_en", 64'(if_id_en), 64'h7);
        chk("rst_bubble", 64'(bubble), 64'h0);
        chk("rst_busy", 64'(busy_v[0]), 64'h0);
        chk("rst_stall_cnt", 64'(sc[0]), 64'h0);
        tick();
        rst = 0;
        tick();

        wr(5, 2); tick();
        cons1(5); #2;
        chk("raw_bubble", 64'(bubble[0]), 64'h1);
        chk("raw_pc_en", 64'(pc_en[0]), 64'h0);
        tick(); #2;
        chk("raw_issue", 64'(pc_en[0]), 64'h1);
        tick();
        idle(); #2;
        chk("raw_stall_cnt", 64'(sc[0]), 64'h1);
        drain();

        wr(7, 1); tick();
        cons2(7); #2;
        chk("nofwd_stall1", 64'(pc_en[1]), 64'h0);
        tick(); #2;
        chk("nofwd_busy7", 64'(busy_v[1][7]), 64'h1);
        chk("nofwd_stall2", 64'(pc_en[1]), 64'h0);
        tick(); #2;
        chk("nofwd_issue", 64'(pc_en[1]), 64'h1);
        chk("nofwd_busy7_clr", 64'(busy_v[1][7]), 64'h0);
        tick();
        idle(); #2;
        chk("nofwd_stall_cnt_b", 64'(sc[1]), 64'd4);
        chk("fwd_stall_cnt_a", 64'(sc[0]), 64'd1);
        drain();

        wr(0, 3); tick();
        cons1(0); #2;
        chk("x0_pc_en", 64'(pc_en), 64'h7);
        chk("x0_busy", 64'(busy_v[0]), 64'h0);
        drain();

        wr(9, 4); tick();
        cons1(9); ext_stall = 1;
        repeat (4) begin
            #2;
            chk("ext_pc_en", 64'(pc_en[0]), 64'h0);
            chk("ext_bubble", 64'(bubble[0]), 64'h0);
            chk("ext_busy9", 64'(busy_v[0][9]), 64'h1);
            tick();
        end
        ext_stall = 0; #2;
        chk("ext_release_bubble", 64'(bubble[0]), 64'h1);
        chk("ext_stall_cnt", 64'(sc[0]), 64'd1);
        repeat (3) tick();
        #2;
        chk("ext_resume_issue", 64'(pc_en[0]), 64'h1);
        chk("ext_stall_cnt_after", 64'(sc[0]), 64'd4);
        drain();

        wr(3, 4); tick();
        cons1(3); flush = 1; #2;
        chk("flush_pc_en", 64'(pc_en[0]), 64'h1);
        chk("flush_bubble", 64'(bubble[0]), 64'h1);
        tick();
        idle(); #2;
        chk("flush_stall_cnt", 64'(sc[0]), 64'd4);
        drain();

        wr(4, 3); tick();
        wr(4, 1); #2;
        chk("waw_busy_c1", 64'(busy_v[0][4]), 64'h1);
        tick();
        idle(); #2;
        chk("waw_busy_c2", 64'(busy_v[0][4]), 64'h1);
        tick(); #2;
        chk("waw_busy_c3", 64'(busy_v[0][4]), 64'h0);
        drain();

        wr(6, 7); tick();
        cons1(6); #2;
        chk("rststall_pre", 64'(pc_en[0]), 64'h0);
        tick();
        rst = 1; #1;
        chk("rststall_pc_en", 64'(pc_en), 64'h7);
        chk("rststall_busy", 64'(busy_v[0]), 64'h0);
        chk("rststall_cnt", 64'(sc[0]), 64'h0);
        idle();
        tick();
        rst = 0;
        tick();

        idle();
        dec_valid = 1; use1 = 1; rs1 = 1; we = 1; rd = 1; lat = 8'd255;
        repeat (66000) tick();
        #2;
        chk("sat_stall_cnt", 64'(sc[2]), 64'hFFFF);
        stat_clr = 1;
        tick();
        stat_clr = 0;
        idle(); #2;
        chk("stat_clr_cnt", 64'(sc[2]), 64'h0);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
